// File: rtl/cvxif_offload_pkg.sv
// Local types for the offload controller: per-id tracking entry and FSM states.
package cvxif_offload_pkg;

    import cvxif_pkg::*;

    localparam int unsigned NumIds = 2 ** X_ID_WIDTH;

    typedef struct packed {
        logic valid;
        logic committed;
        logic writeback;
    } id_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/cvxif_pkg.sv
// CV-X-IF interface types shared by the core-side initiator and the coprocessor.
package cvxif_pkg;

    localparam int unsigned X_NUM_RS    = 2;
    localparam int unsigned X_ID_WIDTH  = 3;
    localparam int unsigned X_RFR_WIDTH = 32;
    localparam int unsigned X_DATAWIDTH = 32;

    typedef struct packed {
        logic [15:0]           instr;
        logic [X_ID_WIDTH-1:0] id;
    } x_compressed_req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        accept;
    } x_compressed_resp_t;

    typedef struct packed {
        logic [31:0]                          instr;
        logic [X_ID_WIDTH-1:0]                id;
        logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs;
        logic [X_NUM_RS-1:0]                  rs_valid;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic dualwrite;
        logic loadstore;
        logic exc;
    } x_issue_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           addr;
        logic                  we;
    } x_mem_req_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           rdata;
        logic                  err;
    } x_mem_result_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_DATAWIDTH-1:0] data;
        logic [4:0]             rd;
        logic                   we;
        logic                   exc;
        logic [5:0]             exccode;
    } x_result_t;

    typedef struct packed {
        logic              x_compressed_valid;
        x_compressed_req_t x_compressed_req;
        logic              x_issue_valid;
        x_issue_req_t      x_issue_req;
        logic              x_commit_valid;
        x_commit_t         x_commit;
        logic              x_mem_ready;
        logic              x_mem_result_valid;
        x_mem_result_t     x_mem_result;
        logic              x_result_ready;
    } cvxif_req_t;

    typedef struct packed {
        logic               x_compressed_ready;
        x_compressed_resp_t x_compressed_resp;
        logic               x_issue_ready;
        x_issue_resp_t      x_issue_resp;
        logic               x_mem_valid;
        x_mem_req_t         x_mem_req;
        logic               x_result_valid;
        x_result_t          x_result;
    } cvxif_resp_t;

endpackage

// File: rtl/cvxif_id_table.sv
// Per-X-ID offload tracking table with three lookup ports and the outstanding counter.
module cvxif_id_table
    import cvxif_pkg::*;
    import cvxif_offload_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  set_i,
    input  logic [X_ID_WIDTH-1:0] set_id_i,
    input  logic                  set_wb_i,
    input  logic                  commit_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  clr_a_i,
    input  logic [X_ID_WIDTH-1:0] clr_a_id_i,
    input  logic                  clr_b_i,
    input  logic [X_ID_WIDTH-1:0] clr_b_id_i,
    input  logic [X_ID_WIDTH-1:0] issue_id_i,
    input  logic [X_ID_WIDTH-1:0] result_id_i,
    input  logic [X_ID_WIDTH-1:0] scan_id_i,
    output id_entry_t             issue_entry_o,
    output id_entry_t             result_entry_o,
    output id_entry_t             scan_entry_o,
    output logic [CntW-1:0]       count_o
);

    id_entry_t [NumIds-1:0] entries_q;
    logic [CntW-1:0]        count_q;
    logic                   set_hit, cmt_hit, clr_a_hit, clr_b_hit;
    logic [NumIds-1:0]      set_vec, cmt_vec, clr_vec;

    // Only transitions on live entries touch the counter; a double clear of one id counts once.
    assign set_hit   = set_i && !entries_q[set_id_i].valid;
    assign cmt_hit   = commit_i && entries_q[commit_id_i].valid;
    assign clr_a_hit = clr_a_i && entries_q[clr_a_id_i].valid;
    assign clr_b_hit = clr_b_i && entries_q[clr_b_id_i].valid &&
                       !(clr_a_hit && (clr_a_id_i == clr_b_id_i));

    assign set_vec = set_hit ? (NumIds'(1) << set_id_i) : '0;
    assign cmt_vec = cmt_hit ? (NumIds'(1) << commit_id_i) : '0;
    assign clr_vec = (clr_a_hit ? (NumIds'(1) << clr_a_id_i) : '0) |
                     (clr_b_hit ? (NumIds'(1) << clr_b_id_i) : '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entries_q <= '0;
            count_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < NumIds; i++) begin
                if (set_vec[i]) begin
                    entries_q[i] <= '{valid: 1'b1, committed: 1'b0, writeback: set_wb_i};
                end else if (clr_vec[i]) begin
                    entries_q[i] <= '0;
                end else if (cmt_vec[i]) begin
                    entries_q[i].committed <= 1'b1;
                end
            end
            count_q <= count_q + CntW'(set_hit) - CntW'(clr_a_hit) - CntW'(clr_b_hit);
        end
    end

    assign issue_entry_o  = entries_q[issue_id_i];
    assign result_entry_o = entries_q[result_id_i];
    assign scan_entry_o   = entries_q[scan_id_i];
    assign count_o        = count_q;

endmodule

// File: rtl/cvxif_offload_ctrl.sv
// Core-side CV-X-IF initiator: issues offloads, tracks them by X-ID, gates results on commit.
module cvxif_offload_ctrl
    import cvxif_pkg::*;
    import cvxif_offload_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic                            issue_valid_i,
    output logic                            issue_ready_o,
    input  logic [31:0]                     issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]           issue_id_i,
    input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] issue_rs_i,
    input  logic [X_NUM_RS-1:0]             issue_rs_valid_i,
    output logic                            issue_done_o,
    output logic [X_ID_WIDTH-1:0]           issue_done_id_o,
    output logic                            issue_accept_o,
    output logic                            issue_writeback_o,
    input  logic                            commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]           commit_id_i,
    input  logic                            commit_kill_i,
    output logic                            result_valid_o,
    input  logic                            result_ready_i,
    output logic [X_ID_WIDTH-1:0]           result_id_o,
    output logic [X_DATAWIDTH-1:0]          result_data_o,
    output logic [4:0]                      result_rd_o,
    output logic                            result_we_o,
    output logic                            result_exc_o,
    output logic [5:0]                      result_exccode_o,
    output logic                            spurious_o,
    output cvxif_req_t                      cvxif_req_o,
    input  cvxif_resp_t                     cvxif_resp_i
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    fsm_state_e            state_q, state_d;
    logic [X_ID_WIDTH-1:0] ptr_q, ptr_d;
    id_entry_t             iss_e, res_e, scan_e;
    logic [CntW-1:0]       count;
    x_result_t             res;
    logic                  slot_ok, x_issue_valid, hs;
    logic                  scan_kill, run_commit, run_kill, retire;
    logic                  clr_a;
    logic [X_ID_WIDTH-1:0] clr_a_id;
    logic                  unused_sig;

    assign res = cvxif_resp_i.x_result;

    assign slot_ok       = !iss_e.valid && (count < CntW'(MaxOutstanding));
    assign x_issue_valid = (state_q == RUN) && issue_valid_i && slot_ok;
    assign hs            = x_issue_valid && cvxif_resp_i.x_issue_ready;
    assign issue_ready_o = hs;

    // Decision is reported one cycle after the handshake; the entry becomes live on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_done_o      <= 1'b0;
            issue_done_id_o   <= '0;
            issue_accept_o    <= 1'b0;
            issue_writeback_o <= 1'b0;
        end else begin
            issue_done_o      <= hs;
            issue_done_id_o   <= hs ? issue_id_i : '0;
            issue_accept_o    <= hs && cvxif_resp_i.x_issue_resp.accept;
            issue_writeback_o <= hs && cvxif_resp_i.x_issue_resp.writeback;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        scan_kill = 1'b0;
        case (state_q)
            RUN: begin
                if (flush_i) begin
                    state_d = FLUSH;
                    ptr_d   = '0;
                end
            end
            FLUSH: begin
                // Committed entries survive the flush and retire through the result path.
                scan_kill = scan_e.valid && !scan_e.committed;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == '1) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign run_commit = (state_q == RUN) && commit_valid_i && !commit_kill_i;
    assign run_kill   = (state_q == RUN) && commit_valid_i && commit_kill_i;
    assign clr_a      = run_kill || scan_kill;
    assign clr_a_id   = (state_q == FLUSH) ? ptr_q : commit_id_i;

    // A result waits for its commit; results for unknown ids are drained so the coprocessor never stalls.
    assign result_valid_o = cvxif_resp_i.x_result_valid && res_e.valid && res_e.committed;
    assign retire         = result_valid_o && result_ready_i;
    assign spurious_o     = cvxif_resp_i.x_result_valid && !res_e.valid;

    assign result_id_o      = res.id;
    assign result_data_o    = res.data;
    assign result_rd_o      = res.rd;
    assign result_we_o      = res.we;
    assign result_exc_o     = res.exc;
    assign result_exccode_o = res.exccode;

    always_comb begin
        cvxif_req_o                      = '0;
        cvxif_req_o.x_issue_valid        = x_issue_valid;
        cvxif_req_o.x_issue_req.instr    = issue_instr_i;
        cvxif_req_o.x_issue_req.id       = issue_id_i;
        cvxif_req_o.x_issue_req.rs       = issue_rs_i;
        cvxif_req_o.x_issue_req.rs_valid = issue_rs_valid_i;
        if (state_q == FLUSH) begin
            cvxif_req_o.x_commit_valid          = scan_kill;
            cvxif_req_o.x_commit.id             = ptr_q;
            cvxif_req_o.x_commit.commit_kill    = scan_kill;
        end else begin
            cvxif_req_o.x_commit_valid          = commit_valid_i;
            cvxif_req_o.x_commit.id             = commit_id_i;
            cvxif_req_o.x_commit.commit_kill    = commit_kill_i;
        end
        cvxif_req_o.x_result_ready = cvxif_resp_i.x_result_valid &&
                                     (!res_e.valid || (res_e.committed && result_ready_i));
    end

    cvxif_id_table #(
        .MaxOutstanding (MaxOutstanding),
        .CntW           (CntW)
    ) u_table (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .set_i          (hs && cvxif_resp_i.x_issue_resp.accept),
        .set_id_i       (issue_id_i),
        .set_wb_i       (cvxif_resp_i.x_issue_resp.writeback),
        .commit_i       (run_commit),
        .commit_id_i    (commit_id_i),
        .clr_a_i        (clr_a),
        .clr_a_id_i     (clr_a_id),
        .clr_b_i        (retire),
        .clr_b_id_i     (res.id),
        .issue_id_i     (issue_id_i),
        .result_id_i    (res.id),
        .scan_id_i      (ptr_q),
        .issue_entry_o  (iss_e),
        .result_entry_o (res_e),
        .scan_entry_o   (scan_e),
        .count_o        (count)
    );

    assign unused_sig = ^{iss_e.committed, iss_e.writeback, res_e.writeback, scan_e.writeback,
                          cvxif_resp_i.x_compressed_ready, cvxif_resp_i.x_compressed_resp,
                          cvxif_resp_i.x_mem_valid, cvxif_resp_i.x_mem_req,
                          cvxif_resp_i.x_issue_resp.dualwrite, cvxif_resp_i.x_issue_resp.loadstore,
                          cvxif_resp_i.x_issue_resp.exc};

endmodule

// File: tb/tb_cvxif_offload_ctrl.sv
// Directed and randomized bench for cvxif_offload_ctrl against an id-state reference model.
module tb_cvxif_offload_ctrl;
    import cvxif_pkg::*;
    import cvxif_offload_pkg::*;

    localparam int MAXO = 4;
    localparam int NI   = int'(NumIds);

    logic                            clk_i = 1'b0;
    logic                            rst_ni = 1'b1;
    logic                            flush_i = 1'b0;
    logic                            issue_valid_i = 1'b0;
    logic                            issue_ready_o;
    logic [31:0]                     issue_instr_i = '0;
    logic [X_ID_WIDTH-1:0]           issue_id_i = '0;
    logic [X_NUM_RS*X_RFR_WIDTH-1:0] issue_rs_i = '0;
    logic [X_NUM_RS-1:0]             issue_rs_valid_i = '0;
    logic                            issue_done_o;
    logic [X_ID_WIDTH-1:0]           issue_done_id_o;
    logic                            issue_accept_o, issue_writeback_o;
    logic                            commit_valid_i = 1'b0;
    logic [X_ID_WIDTH-1:0]           commit_id_i = '0;
    logic                            commit_kill_i = 1'b0;
    logic                            result_valid_o;
    logic                            result_ready_i = 1'b0;
    logic [X_ID_WIDTH-1:0]           result_id_o;
    logic [X_DATAWIDTH-1:0]          result_data_o;
    logic [4:0]                      result_rd_o;
    logic                            result_we_o, result_exc_o;
    logic [5:0]                      result_exccode_o;
    logic                            spurious_o;
    cvxif_req_t                      req;
    cvxif_resp_t                     resp = '0;

    always #5 clk_i = ~clk_i;

    cvxif_offload_ctrl #(.MaxOutstanding(MAXO)) dut (
        .clk_i, .rst_ni, .flush_i,
        .issue_valid_i, .issue_ready_o, .issue_instr_i, .issue_id_i, .issue_rs_i, .issue_rs_valid_i,
        .issue_done_o, .issue_done_id_o, .issue_accept_o, .issue_writeback_o,
        .commit_valid_i, .commit_id_i, .commit_kill_i,
        .result_valid_o, .result_ready_i, .result_id_o, .result_data_o, .result_rd_o,
        .result_we_o, .result_exc_o, .result_exccode_o, .spurious_o,
        .cvxif_req_o(req), .cvxif_resp_i(resp)
    );

    // Model: per id 0 = free, 1 = outstanding, 2 = outstanding and committed.
    int st [NI];
    int flush_left;
    bit dn_v, dn_acc, dn_wb;
    int dn_id;
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        foreach (st[i]) st[i] = 0;
        flush_left = 0;
        dn_v = 0; dn_acc = 0; dn_wb = 0; dn_id = 0;
    endtask

    task automatic idle();
        issue_valid_i = 1'b0; commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        flush_i = 1'b0; result_ready_i = 1'b1; resp = '0;
    endtask

    function automatic logic [X_ID_WIDTH-1:0] pick();
        int live[$];
        foreach (st[i]) if (st[i] != 0) live.push_back(i);
        if (live.size() > 0 && $urandom_range(0, 3) != 0)
            return X_ID_WIDTH'(live[$urandom_range(0, live.size() - 1)]);
        return X_ID_WIDTH'($urandom_range(0, NI - 1));
    endfunction

    // Check one cycle against the model at the falling edge, then advance the model.
    task automatic cycle();
        int cnt, iid, cid, rid, p;
        bit fl, e_ixv, e_hs, e_cv, e_ov, e_sp, e_rr;
        int nst [NI];
        @(negedge clk_i);
        cnt = 0;
        foreach (st[i]) if (st[i] != 0) cnt++;
        fl  = flush_left > 0;
        p   = NI - flush_left;
        iid = int'(issue_id_i); cid = int'(commit_id_i); rid = int'(resp.x_result.id);

        e_ixv = !fl && issue_valid_i && st[iid] == 0 && cnt < MAXO;
        e_hs  = e_ixv && resp.x_issue_ready;
        chk("x_issue_valid", req.x_issue_valid, e_ixv);
        chk("issue_ready", issue_ready_o, e_hs);
        if (e_ixv) chk("issue_instr_fwd", req.x_issue_req.instr, issue_instr_i);
        chk("issue_done", issue_done_o, dn_v);
        chk("issue_done_id", issue_done_id_o, dn_id);
        chk("issue_accept", issue_accept_o, dn_acc);
        chk("issue_writeback", issue_writeback_o, dn_wb);
        chk("count", dut.u_table.count_o, cnt);
        chk("count_le_max", dut.u_table.count_o <= MAXO, 1);

        if (fl) begin
            e_cv = (st[p] == 1);
            chk("flush_commit_valid", req.x_commit_valid, e_cv);
            if (e_cv) begin
                chk("flush_kill_id", req.x_commit.id, p);
                chk("flush_kill_bit", req.x_commit.commit_kill, 1);
            end
        end else begin
            chk("commit_valid_fwd", req.x_commit_valid, commit_valid_i);
            if (commit_valid_i) begin
                chk("commit_id_fwd", req.x_commit.id, commit_id_i);
                chk("commit_kill_fwd", req.x_commit.commit_kill, commit_kill_i);
            end
        end

        e_ov = resp.x_result_valid && st[rid] == 2;
        e_sp = resp.x_result_valid && st[rid] == 0;
        e_rr = resp.x_result_valid && (st[rid] == 0 || (st[rid] == 2 && result_ready_i));
        chk("result_valid", result_valid_o, e_ov);
        chk("spurious", spurious_o, e_sp);
        chk("x_result_ready", req.x_result_ready, e_rr);
        if (e_ov) begin
            chk("result_id", result_id_o, resp.x_result.id);
            chk("result_data", result_data_o, resp.x_result.data);
            chk("result_rd", result_rd_o, resp.x_result.rd);
            chk("result_we", result_we_o, resp.x_result.we);
            chk("result_exccode", result_exccode_o, resp.x_result.exccode);
        end
        chk("tieoffs", {req.x_compressed_valid, req.x_mem_ready, req.x_mem_result_valid}, 0);

        nst = st;
        if (e_hs && resp.x_issue_resp.accept) nst[iid] = 1;
        if (fl) begin
            if (st[p] == 1) nst[p] = 0;
        end else if (commit_valid_i && st[cid] != 0) begin
            nst[cid] = commit_kill_i ? 0 : 2;
        end
        if (e_ov && result_ready_i) nst[rid] = 0;
        st = nst;
        if (fl) flush_left--;
        else if (flush_i) flush_left = NI;
        dn_v   = e_hs;
        dn_id  = e_hs ? iid : 0;
        dn_acc = e_hs && resp.x_issue_resp.accept;
        dn_wb  = e_hs && resp.x_issue_resp.writeback;
        @(posedge clk_i); #1;
    endtask

    task automatic do_issue(input int id, input bit acc, input bit wb);
        idle();
        issue_valid_i = 1'b1; issue_id_i = X_ID_WIDTH'(id); issue_instr_i = 32'h0000_000B;
        issue_rs_i = {$urandom, $urandom}; issue_rs_valid_i = '1;
        resp.x_issue_ready = 1'b1; resp.x_issue_resp.accept = acc; resp.x_issue_resp.writeback = wb;
        cycle();
        idle();
    endtask

    task automatic do_commit(input int id, input bit kill);
        idle();
        commit_valid_i = 1'b1; commit_id_i = X_ID_WIDTH'(id); commit_kill_i = kill;
        cycle();
        idle();
    endtask

    task automatic set_result(input int id, input logic [31:0] data);
        resp.x_result_valid = 1'b1; resp.x_result.id = X_ID_WIDTH'(id);
        resp.x_result.data = data; resp.x_result.rd = 5'(id + 3); resp.x_result.we = 1'b1;
    endtask

    initial begin
        model_reset();
        idle();
        #1 rst_ni = 1'b0;
        #2;
        chk("rst_done", issue_done_o, 0);
        chk("rst_result_valid", result_valid_o, 0);
        chk("rst_spurious", spurious_o, 0);
        chk("rst_req_zero", req == '0, 1);
        chk("rst_count", dut.u_table.count_o, 0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;
        cycle();

        // Basic issue/commit/result for id 2
        do_issue(2, 1, 1);
        cycle();
        do_commit(2, 0);
        set_result(2, 32'h5);
        cycle();
        idle(); cycle();

        // Result for id 1 arrives before its commit
        do_issue(1, 1, 0);
        set_result(1, 32'hA1); cycle();
        cycle();
        commit_valid_i = 1'b1; commit_id_i = 1; cycle();
        commit_valid_i = 1'b0; cycle();
        idle(); cycle();

        // Fill to MaxOutstanding, a 5th waits for a retire
        for (int i = 0; i < 4; i++) do_issue(i, 1, 1);
        issue_valid_i = 1'b1; issue_id_i = 4; resp.x_issue_ready = 1'b1;
        resp.x_issue_resp.accept = 1'b1; resp.x_issue_resp.writeback = 1'b1;
        cycle(); cycle();
        commit_valid_i = 1'b1; commit_id_i = 0; cycle();
        commit_valid_i = 1'b0; set_result(0, 32'h77); cycle();
        resp.x_result_valid = 1'b0; cycle();
        idle(); cycle();
        for (int i = 1; i <= 4; i++) begin
            do_commit(i, 0);
            set_result(i, 32'(i * 16)); cycle();
            idle();
        end
        cycle();

        // Flush with ids 0,3 uncommitted and id 1 committed
        do_issue(0, 1, 1); do_issue(1, 1, 1); do_issue(3, 1, 0);
        do_commit(1, 0);
        flush_i = 1'b1; cycle();
        flush_i = 1'b0; set_result(1, 32'hBEEF); cycle();
        idle();
        for (int i = 1; i < NI; i++) begin
            flush_i = (i == 3);
            cycle();
        end
        idle();
        do_issue(3, 1, 1);
        do_commit(3, 1);

        // Spurious result, then a rejected offload that is still committed
        set_result(5, 32'h55); cycle();
        idle();
        do_issue(6, 0, 1);
        cycle();
        do_commit(6, 0);
        cycle();

        // Asynchronous reset in the middle of a decision
        do_issue(2, 1, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_done", issue_done_o, 0);
        chk("midrst_count", dut.u_table.count_o, 0);
        model_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        cycle();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            idle();
            issue_valid_i = 1'($urandom_range(0, 1));
            issue_id_i = X_ID_WIDTH'($urandom_range(0, NI - 1));
            issue_instr_i = $urandom;
            resp.x_issue_ready = ($urandom_range(0, 3) != 0);
            resp.x_issue_resp.accept = ($urandom_range(0, 3) != 0);
            resp.x_issue_resp.writeback = 1'($urandom_range(0, 1));
            commit_valid_i = ($urandom_range(0, 2) == 0);
            commit_id_i = pick();
            commit_kill_i = ($urandom_range(0, 4) == 0);
            flush_i = ($urandom_range(0, 59) == 0);
            resp.x_result_valid = 1'($urandom_range(0, 1));
            resp.x_result.id = pick();
            resp.x_result.data = $urandom;
            resp.x_result.rd = 5'($urandom_range(0, 31));
            resp.x_result.we = 1'($urandom_range(0, 1));
            resp.x_result.exccode = 6'($urandom_range(0, 63));
            result_ready_i = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
